// File: rtl/mux_4_to_1_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4-to-1 mux.
// Optional forced rotation after HOLD_MAX cycles is enabled by `define MUX_ARB_TIMEOUT_EN.
module mux_4_to_1_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic             valid,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       nxt;
    logic             take;

    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
        $error("mux_4_to_1_arbiter: illegal HOLD_MAX/CNT_W");
    end

    // Search p+1, p+2, p+3, p; p itself is the lowest-priority candidate.
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] res;
        res = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = idx;
        end
        return res;
    endfunction

    // While granted, last_q always equals sel_q, so one pointer serves both states.
    assign nxt = pick(last_q, req);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) take = 1'b1;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    if (hold_q == CNT_W'(HOLD_MAX - 1)) take = 1'b1;
                    else                                hold_d = hold_q + CNT_W'(1);
`else
                    if (hold_q != '1) hold_d = hold_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = GRANT;
            sel_d   = nxt;
            last_d  = nxt;
            grant_d = 4'b0001 << nxt;
            valid_d = 1'b1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign sel      = sel_q;
    assign grant    = grant_q;
    assign valid    = valid_q;
    assign hold_cnt = hold_q;

endmodule
